// File: rtl/exe_mem_pipe.sv
// rtl/exe_mem_pipe.sv - execute-to-memory pipeline boundary with NZCV status register
//
// Optional feature macro: EXE_MEM_SKID_EN
//   defined   : head + skid entries, registered in_ready (= !skid_valid)
//   undefined : head entry only, in_ready = !head_valid || out_ready
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 branch-taken flush, drops buffered entries and current input
//   in_valid / in_ready   execute-side handshake
//   alu_result_in, status_in, s_in, wb_en_in, mem_r_en_in, mem_w_en_in,
//   dest_in, val_rm_in    instruction fields from execute
//   out_valid / out_ready memory-side handshake
//   alu_result_out, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out,
//   val_rm_out            head entry fields
//   sr                    status register {N,Z,C,V}, fed back to the ALU

module exe_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [3:0]        status_in,
    input  logic              s_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic [DATA_W-1:0] val_rm_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [3:0]        sr
);

    // Entry layout: {alu_result, wb_en, mem_r_en, mem_w_en, dest, val_rm}
    localparam int EW = 2 * DATA_W + DEST_W + 3;

    logic [EW-1:0] in_entry;
    logic          in_xfer;
    logic          out_xfer;

    logic          head_valid_q, head_valid_d;
    logic [EW-1:0] head_q, head_d;
    logic [3:0]    sr_q, sr_d;

    logic          head_wb_en;
    logic          head_mem_r_en;
    logic          head_mem_w_en;

    assign in_entry = {alu_result_in, wb_en_in, mem_r_en_in, mem_w_en_in, dest_in, val_rm_in};
    assign in_xfer  = in_valid && in_ready && !flush;
    assign out_xfer = head_valid_q && out_ready;

    // Flags are committed when the instruction is accepted, so a dependent
    // ADC/SBC right behind it already sees the new carry.
    always_comb begin
        sr_d = sr_q;
        if (in_xfer && s_in) begin
            sr_d = status_in;
        end
    end

`ifdef EXE_MEM_SKID_EN
    logic          skid_valid_q, skid_valid_d;
    logic [EW-1:0] skid_q, skid_d;

    // Registered ready: the skid slot absorbs the one instruction that can
    // arrive in the cycle the memory stage stalls.
    assign in_ready = !skid_valid_q;

    always_comb begin
        head_valid_d = head_valid_q;
        head_d       = head_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_xfer) begin
            if (skid_valid_q) begin
                head_d = skid_q;
                if (in_xfer) begin
                    skid_d = in_entry;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (in_xfer) begin
                head_d = in_entry;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            // in_ready guarantees skid is empty here
            if (!head_valid_q) begin
                head_valid_d = 1'b1;
                head_d       = in_entry;
            end else begin
                skid_valid_d = 1'b1;
                skid_d       = in_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end
`else
    assign in_ready = !head_valid_q || out_ready;

    always_comb begin
        head_valid_d = head_valid_q;
        head_d       = head_q;
        if (flush) begin
            head_valid_d = 1'b0;
        end else if (in_xfer) begin
            head_valid_d = 1'b1;
            head_d       = in_entry;
        end else if (out_xfer) begin
            head_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid_q <= 1'b0;
            head_q       <= '0;
            sr_q         <= 4'b0000;
        end else begin
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
            sr_q         <= sr_d;
        end
    end

    assign {alu_result_out, head_wb_en, head_mem_r_en, head_mem_w_en, dest_out, val_rm_out} = head_q;

    // Side-effecting controls must never leak from a stale head entry.
    assign out_valid    = head_valid_q;
    assign wb_en_out    = head_wb_en && head_valid_q;
    assign mem_r_en_out = head_mem_r_en && head_valid_q;
    assign mem_w_en_out = head_mem_w_en && head_valid_q;
    assign sr           = sr_q;

endmodule

// File: tb/tb_exe_mem_pipe.sv
// tb/tb_exe_mem_pipe.sv - scoreboard bench for exe_mem_pipe
module tb_exe_mem_pipe;

    localparam int DATA_W = 32;
    localparam int DEST_W = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_result_in;
    logic [3:0]        status_in;
    logic              s_in;
    logic              wb_en_in;
    logic              mem_r_en_in;
    logic              mem_w_en_in;
    logic [DEST_W-1:0] dest_in;
    logic [DATA_W-1:0] val_rm_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_result_out;
    logic              wb_en_out;
    logic              mem_r_en_out;
    logic              mem_w_en_out;
    logic [DEST_W-1:0] dest_out;
    logic [DATA_W-1:0] val_rm_out;
    logic [3:0]        sr;

    exe_mem_pipe #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result_in(alu_result_in), .status_in(status_in), .s_in(s_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .dest_in(dest_in), .val_rm_in(val_rm_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result_out(alu_result_out), .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .dest_out(dest_out), .val_rm_out(val_rm_out), .sr(sr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [2*DATA_W+DEST_W+2:0] ent_t;
    ent_t exp_q[$];

    int total     = 0;
    int pass_cnt  = 0;
    int out_cnt   = 0;
    int stall_cyc = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every output transfer is checked against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: got alu=0x%0h expected no output", alu_result_out);
            end else begin
                chk("out_entry",
                    {alu_result_out, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out, val_rm_out},
                    exp_q.pop_front());
            end
            out_cnt++;
        end
    end

    // Leaves in_valid high so consecutive calls form a back-to-back stream.
    task automatic send(input logic [31:0] alu, input logic [3:0] dest, input logic wb,
                        input logic mr, input logic mw, input logic [31:0] rm,
                        input logic s, input logic [3:0] st);
        int waits;
        waits         = 0;
        in_valid      = 1'b1;
        alu_result_in = alu;
        dest_in       = dest;
        wb_en_in      = wb;
        mem_r_en_in   = mr;
        mem_w_en_in   = mw;
        val_rm_in     = rm;
        s_in          = s;
        status_in     = st;
        @(negedge clk);
        while (!in_ready) begin
            waits++;
            stall_cyc++;
            if (waits > 20) begin
                total++;
                $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waits);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            @(negedge clk);
        end
        exp_q.push_back({alu, wb, mr, mw, dest, rm});
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        s_in     = 1'b0;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int s0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_result_in = '0; status_in = '0; s_in = 1'b0; wb_en_in = 1'b0;
        mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; dest_in = '0; val_rm_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_sr", sr, 4'b0000);
        chk("rst_alu", alu_result_out, 32'h0);
        chk("rst_dest", dest_out, 4'h0);
        chk("rst_val_rm", val_rm_out, 32'h0);
        chk("rst_ctrl", {wb_en_out, mem_r_en_out, mem_w_en_out}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single pass, latency 1
        out_ready = 1'b1;
        send(32'h0000_0005, 4'd3, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000);
        idle();
        @(negedge clk);
        chk("single_out_valid", out_valid, 1'b1);
        chk("single_alu", alu_result_out, 32'h5);
        chk("single_dest", dest_out, 4'd3);
        chk("single_wb", wb_en_out, 1'b1);
        @(posedge clk); #1;
        drain();

        // Flag update at acceptance; s_in=0 holds
        send(32'h0, 4'd1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0110);
        idle();
        @(negedge clk);
        chk("sr_update", sr, 4'b0110);
        @(posedge clk); #1;
        send(32'h1, 4'd2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'b1001);
        idle();
        @(negedge clk);
        chk("sr_hold", sr, 4'b0110);
        @(posedge clk); #1;
        drain();

        // Stall / skid
        out_ready = 1'b0;
`ifdef EXE_MEM_SKID_EN
        send(32'h11, 4'd4, 1'b1, 1'b0, 1'b0, 32'hA1, 1'b0, 4'b0000);
        send(32'h22, 4'd5, 1'b1, 1'b0, 1'b0, 32'hA2, 1'b0, 4'b0000);
        idle();
        @(negedge clk);
        chk("stall_in_ready_full", in_ready, 1'b0);
        chk("stall_head_held", alu_result_out, 32'h11);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_first", alu_result_out, 32'h11);
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_second", alu_result_out, 32'h22);
        chk("release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
`else
        send(32'h11, 4'd4, 1'b1, 1'b0, 1'b0, 32'hA1, 1'b0, 4'b0000);
        idle();
        @(negedge clk);
        chk("stall_in_ready_full", in_ready, 1'b0);
        chk("stall_head_held", alu_result_out, 32'h11);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        send(32'h22, 4'd5, 1'b1, 1'b0, 1'b0, 32'hA2, 1'b0, 4'b0000);
        idle();
`endif
        drain();

        // Flush with buffered stores and a flag-setting input in the same cycle
        out_ready = 1'b0;
        send(32'h33, 4'd6, 1'b0, 1'b0, 1'b1, 32'hB3, 1'b0, 4'b0000);
`ifdef EXE_MEM_SKID_EN
        send(32'h44, 4'd7, 1'b0, 1'b0, 1'b1, 32'hB4, 1'b0, 4'b0000);
`endif
        flush = 1'b1;
        in_valid = 1'b1; s_in = 1'b1; status_in = 4'b1111;
        alu_result_in = 32'h99; mem_w_en_in = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_sr", sr, 4'b0110);
        chk("flush_mem_w", mem_w_en_out, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_dropped_input", out_valid, 1'b0);
        @(posedge clk); #1;

        // Reset mid-stall
        send(32'h55, 4'd8, 1'b1, 1'b1, 1'b0, 32'hC5, 1'b1, 4'b1010);
`ifdef EXE_MEM_SKID_EN
        send(32'h66, 4'd9, 1'b1, 1'b0, 1'b1, 32'hC6, 1'b0, 4'b0000);
`endif
        idle();
        @(negedge clk);
        chk("pre_rst_sr", sr, 4'b1010);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_sr", sr, 4'b0000);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_alu", alu_result_out, 32'h0);
        chk("midrst_dest", dest_out, 4'h0);
        chk("midrst_val_rm", val_rm_out, 32'h0);
        chk("midrst_ctrl", {wb_en_out, mem_r_en_out, mem_w_en_out}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;

        // Throughput: 8 back-to-back instructions, no bubbles
        out_ready = 1'b1;
        c0 = out_cnt;
        s0 = stall_cyc;
        for (int i = 0; i < 8; i++) begin
            send(32'h100 + i, i[3:0], 1'b1, i[0], i[1], 32'h200 + i, 1'b0, 4'b0000);
        end
        idle();
        @(posedge clk); #1;
        chk("tput_outputs", out_cnt - c0, 8);
        chk("tput_no_stall", stall_cyc - s0, 0);
        chk("tput_scoreboard_empty", exp_q.size(), 0);

        drain();
        @(negedge clk);
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
